// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : Transmit-side consumer of the 16750 TX FIFO. Pops one character
//            per frame from the FIFO head and shifts it out LSB-first as
//            start / data / [parity] / stop bits on SOUT, paced by the baud
//            generator's oversample strobe TXCLK.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   OVERSAMPLE  TXCLK strobes per bit period (even, >= 4)
//   DATA_W      FIFO data width, also the maximum word length
// Ports
//   CLK         in   1       system clock
//   RST         in   1       synchronous active-high reset
//   TXCLK       in   1       baud oversample enable, 1-cycle pulse
//   TXSTART     in   1       FIFO not empty
//   DIN         in   DATA_W  FIFO head data
//   WLS         in   2       word length: 00=5, 01=6, 10=7, 11=8 bits
//   STB         in   1       stop bits: 0=1; 1=1.5 (5-bit) or 2
//   PEN         in   1       parity enable
//   EPS         in   1       even parity select
//   SP          in   1       stick parity
//   BC          in   1       break control (forces SOUT low)
//   READ        out  1       FIFO pop strobe, 1 cycle
//   TXFINISHED  out  1       serializer idle (shift register empty)
//   SOUT        out  1       serial out, registered, idle high
// ============================================================================
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TXCLK,
    input  logic              TXSTART,
    input  logic [DATA_W-1:0] DIN,
    input  logic [1:0]        WLS,
    input  logic              STB,
    input  logic              PEN,
    input  logic              EPS,
    input  logic              SP,
    input  logic              BC,
    output logic              READ,
    output logic              TXFINISHED,
    output logic              SOUT
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_PAR   = 3'd3;
    localparam logic [2:0] c_STOP  = 3'd4;

    // Tick counter must reach 2*OVERSAMPLE-1 for the two-stop-bit case.
    localparam int c_TICK_W = $clog2(2 * OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_W);

    localparam logic [c_TICK_W-1:0] c_BIT_LAST    = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_STOP15_LAST = c_TICK_W'((3 * OVERSAMPLE) / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_STOP2_LAST  = c_TICK_W'(2 * OVERSAMPLE - 1);

    // ------------------------------------------------------------------------
    // State and frame registers
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_wls;
    logic                r_stb;
    logic                r_pen;
    logic                r_eps;
    logic                r_sp;
    logic                r_finished;
    logic                r_sout;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]   w_din_mask;
    logic [c_TICK_W-1:0] w_tick_last;
    logic [c_BIT_W-1:0]  w_last_idx;
    logic                w_bit_done;
    logic                w_load;
    logic                w_par;
    logic                w_line;

    // Keep only the low 5+WLS bits of the FIFO word so the parity reduction
    // over the latched character needs no further masking.
    always_comb begin
        w_din_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < 5 + int'(WLS)) begin
                w_din_mask[i] = 1'b1;
            end
        end
    end

    // Length of the bit currently on the line, expressed as the last tick index.
    always_comb begin
        w_tick_last = c_BIT_LAST;
        if (r_state == c_STOP && r_stb) begin
            w_tick_last = (r_wls == 2'b00) ? c_STOP15_LAST : c_STOP2_LAST;
        end
    end

    // Index of the final data bit: N-1 = 4 + WLS.
    assign w_last_idx = c_BIT_W'(r_wls) + c_BIT_W'(4);

    assign w_bit_done = TXCLK && (r_tick == w_tick_last);

    // A new character is taken either from idle or exactly at the end of the
    // stop period, which gives back-to-back frames without an idle gap.
    // The pop is combinational so it coincides with the cycle DIN is latched.
    assign w_load = TXSTART && ((r_state == c_IDLE) ||
                                ((r_state == c_STOP) && w_bit_done));

    // Stick parity sends a constant; otherwise XOR (EPS=1) or XNOR (EPS=0)
    // of the already-masked data bits.
    assign w_par = r_sp ? ~r_eps : (r_eps ? (^r_data) : ~(^r_data));

    // Line level implied by the current state; registered into SOUT.
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            c_START: w_line = 1'b0;
            c_DATA:  w_line = r_data[r_bit];
            c_PAR:   w_line = w_par;
            default: w_line = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= c_IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_data     <= '0;
            r_wls      <= 2'b00;
            r_stb      <= 1'b0;
            r_pen      <= 1'b0;
            r_eps      <= 1'b0;
            r_sp       <= 1'b0;
            r_finished <= 1'b1;
            r_sout     <= 1'b1;
        end else begin
            // Break overrides the line but leaves the sequencer running.
            r_sout <= BC ? 1'b0 : w_line;

            if (w_load) begin
                r_data     <= DIN & w_din_mask;
                r_wls      <= WLS;
                r_stb      <= STB;
                r_pen      <= PEN;
                r_eps      <= EPS;
                r_sp       <= SP;
                r_state    <= c_START;
                r_tick     <= '0;
                r_bit      <= '0;
                r_finished <= 1'b0;
            end else if (r_state == c_IDLE) begin
                // TXCLK is deliberately ignored while idle.
                r_tick <= '0;
                r_bit  <= '0;
            end else if (TXCLK) begin
                if (w_bit_done) begin
                    r_tick <= '0;
                    case (r_state)
                        c_START: begin
                            r_state <= c_DATA;
                            r_bit   <= '0;
                        end
                        c_DATA: begin
                            if (r_bit == w_last_idx) begin
                                r_state <= r_pen ? c_PAR : c_STOP;
                            end else begin
                                r_bit <= r_bit + c_BIT_W'(1);
                            end
                        end
                        c_PAR: begin
                            r_state <= c_STOP;
                        end
                        c_STOP: begin
                            // Reached only when no further character waits.
                            r_state    <= c_IDLE;
                            r_finished <= 1'b1;
                        end
                        default: begin
                            r_state <= c_IDLE;
                        end
                    endcase
                end else begin
                    r_tick <= r_tick + c_TICK_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign READ       = w_load;
    assign TXFINISHED = r_finished;
    assign SOUT       = r_sout;

endmodule
`default_nettype wire
